ahb_resp_mux: RTL and testbench
===============================

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameter DW, default 32, read data width for master and slave HRDATA.
REQ-002 Parameter NS, default 4, number of slaves; fixed to match the 4-bit HSELx decode.
REQ-003 HCLK  input  1  single clock; all state updates on posedge HCLK.
REQ-004 HRESET  input  1  reset, synchronous and active-high.
REQ-005 HADDR  input  32  address-phase address from the master.
REQ-006 HTRANS  input  2  address-phase transfer type; bit1=1 means NONSEQ/SEQ.
REQ-007 HSELx  input  NS  address-phase one-hot slave select from the decoder.
REQ-008 HERROR  input  1  address-phase unmapped-address flag from the decoder.
REQ-009 HRDATA_S  input  NS*DW  slave read data; slave i occupies bits [i*DW +: DW].
REQ-010 HREADYOUT_S  input  NS  per-slave ready.
REQ-011 HRESP_S  input  NS  per-slave response; 1 means ERROR.
REQ-012 HRDATA  output  DW  muxed read data to the master.
REQ-013 HREADY  output  1  muxed ready to the master; also fed back to all slaves.
REQ-014 HRESP  output  1  muxed response to the master.
REQ-015 ERR_CLR  input  1  synchronous clear of ERR_CNT and ERR_ADDR.
REQ-016 ERR_CNT  output  16  saturating count of default-slave error responses.
REQ-017 ERR_ADDR  output  32  HADDR of the most recent transfer routed to the default slave.

Function
REQ-018 Address phase is accepted on a posedge HCLK where HREADY=1.
- HREADY=0: data-phase state holds.
REQ-019 Define unmapped = HERROR=1, or HSELx=0, or HSELx not one-hot.
REQ-020 On accept, sel_dp SHALL load HSELx when the transfer is mapped; otherwise it loads 0.
REQ-021 On accept with HTRANS[1]=0 (IDLE/BUSY), sel_dp SHALL load 0 and the data phase is OKAY with zero wait.
REQ-022 With sel_dp one-hot on slave i, HRDATA, HREADY and HRESP SHALL combinationally equal HRDATA_S[i], HREADYOUT_S[i] and HRESP_S[i], with no added latency.
REQ-023 With sel_dp=0 and the default-slave FSM in DS_IDLE, outputs SHALL be HREADY=1, HRESP=0, HRDATA=0.
REQ-024 Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
REQ-025 DS_IDLE -> DS_ERR1 on accept with HTRANS[1]=1 and unmapped.
REQ-026 DS_ERR1 drives HREADY=0, HRESP=1, HRDATA=0.
- Always advances to DS_ERR2 on the next cycle.
- Address inputs are ignored while in DS_ERR1.
REQ-027 DS_ERR2 drives HREADY=1, HRESP=1, HRDATA=0.
- Next state is DS_ERR1 if the transfer accepted in this cycle is NONSEQ/SEQ and unmapped.
- Otherwise next state is DS_IDLE.
REQ-028 In DS_ERR2, an accepted mapped transfer SHALL load sel_dp normally, so that slave's data phase follows immediately.
REQ-029 On each entry to DS_ERR1, ERR_ADDR SHALL load the accepted HADDR and ERR_CNT SHALL increment by 1.
- ERR_CNT saturates at 16'hFFFF; no wrap.
REQ-030 ERR_CLR=1 SHALL set ERR_CNT=0 and ERR_ADDR=0 on the next edge.
- If an increment occurs in the same cycle, the clear wins: the result is ERR_CNT=0.
REQ-031 HRESET has priority over every other update.

Reset
REQ-032 While HRESET=1 at posedge HCLK, the block SHALL set sel_dp=0, FSM=DS_IDLE, ERR_CNT=0, ERR_ADDR=0.
- Resulting outputs: HREADY=1, HRESP=0, HRDATA=0.
REQ-033 Reset asserted mid-error (DS_ERR1 or DS_ERR2) SHALL abort the response; outputs show the REQ-032 values from the following cycle.

Verification
REQ-034 Mapped read: NONSEQ, HSELx=4'b0100, HRDATA_S[2]=32'hDEADBEEF, HREADYOUT_S[2]=1 -> next cycle HRDATA=32'hDEADBEEF, HREADY=1, HRESP=0.
REQ-035 Wait states: slave 1 selected, HREADYOUT_S[1] low for 3 cycles -> HREADY low exactly 3 cycles; sel_dp holds; HSELx changes during the stall are ignored.
REQ-036 Unmapped: NONSEQ, HERROR=1, HADDR=32'hF000_0010 -> then HREADY=0/HRESP=1, then HREADY=1/HRESP=1; ERR_CNT=1, ERR_ADDR=32'hF000_0010.
REQ-037 Back-to-back: two unmapped NONSEQ transfers, the second accepted in DS_ERR2, then a mapped transfer to slave 0 -> two full two-cycle error responses, then slave 0 data; ERR_CNT=2.
REQ-038 Edge cases:
- IDLE with HSELx=0 -> OKAY, zero wait, ERR_CNT unchanged.
- HSELx=4'b0011 with NONSEQ -> error response.
- ERR_CNT preloaded to 16'hFFFF by 65535 errors -> stays at 16'hFFFF.
- ERR_CLR coincident with an error -> ERR_CNT=0.
REQ-039 HRESET=1 asserted during DS_ERR1 -> next cycle HREADY=1, HRESP=0, ERR_CNT=0.

Source files
------------

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave response multiplexer with a built-in default slave.
// Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR response and are logged.
module ahb_resp_mux #(
    parameter int unsigned DW = 32,
    parameter int unsigned NS = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [NS-1:0]    HSELx,
    input  logic             HERROR,
    input  logic [NS*DW-1:0] HRDATA_S,
    input  logic [NS-1:0]    HREADYOUT_S,
    input  logic [NS-1:0]    HRESP_S,
    output logic [DW-1:0]    HRDATA,
    output logic             HREADY,
    output logic             HRESP,
    input  logic             ERR_CLR,
    output logic [15:0]      ERR_CNT,
    output logic [31:0]      ERR_ADDR
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    ds_state_e       state_q, state_d;
    logic [NS-1:0]   sel_dp_q, sel_dp_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [31:0]     err_addr_q, err_addr_d;

    logic [NS-1:0]   sel_m1;
    logic            sel_onehot;
    logic            mapped;
    logic            active;
    logic            accept;
    logic            err_req;
    logic            err_entry;

    logic [DW-1:0]   slv_rdata;
    logic            slv_ready;
    logic            slv_resp;

    // Address-phase decode
    assign sel_m1     = HSELx - NS'(1);
    assign sel_onehot = (HSELx != '0) && ((HSELx & sel_m1) == '0);
    assign mapped     = !HERROR && sel_onehot;
    assign active     = HTRANS[1];
    assign accept     = HREADY;
    assign err_req    = active && !mapped;

    // Data-phase slave mux; sel_dp_q is only ever zero or one-hot
    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = 1'b0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (sel_dp_q[i]) begin
                slv_rdata = HRDATA_S[i*DW +: DW];
                slv_ready = HREADYOUT_S[i];
                slv_resp  = HRESP_S[i];
            end
        end
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= DS_IDLE;
            sel_dp_q   <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_dp_q   <= sel_dp_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        sel_dp_d = sel_dp_q;
        if (accept) begin
            sel_dp_d = (active && mapped) ? HSELx : '0;
        end
        unique case (state_q)
            DS_IDLE: if (accept && err_req) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = err_req ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    // Error log; a coincident clear beats the increment
    assign err_entry = (state_d == DS_ERR1) && (state_q != DS_ERR1);

    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (ERR_CLR) begin
            err_cnt_d  = '0;
            err_addr_d = '0;
        end else if (err_entry) begin
            err_addr_d = HADDR;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // Output logic
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        unique case (state_q)
            DS_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            DS_ERR2: begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
            default: begin
                HRDATA = slv_rdata;
                HREADY = slv_ready;
                HRESP  = slv_resp;
            end
        endcase
    end

    assign ERR_CNT  = err_cnt_q;
    assign ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed table-driven bench for ahb_resp_mux plus a counter saturation sequence.
module tb_ahb_resp_mux;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [3:0]   HSELx;
    logic         HERROR;
    logic [127:0] HRDATA_S;
    logic [3:0]   HREADYOUT_S;
    logic [3:0]   HRESP_S;
    logic [31:0]  HRDATA;
    logic         HREADY;
    logic         HRESP;
    logic         ERR_CLR;
    logic [15:0]  ERR_CNT;
    logic [31:0]  ERR_ADDR;

    int errors = 0;
    int checks = 0;

    always #5 HCLK = ~HCLK;

    ahb_resp_mux #(.DW(32), .NS(4)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSELx       (HSELx),
        .HERROR      (HERROR),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .ERR_CLR     (ERR_CLR),
        .ERR_CNT     (ERR_CNT),
        .ERR_ADDR    (ERR_ADDR)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  trans;
        logic [3:0]  sel;
        logic        herr;
        logic [31:0] addr;
        logic [3:0]  rdy_s;
        logic [3:0]  resp_s;
        logic        clr;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
        logic [31:0] e_eaddr;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] BSY = 2'b01;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [1:0] SEQ = 2'b11;

    function automatic vec_t mk(logic rst, logic [1:0] trans, logic [3:0] sel, logic herr,
                                logic [31:0] addr, logic [3:0] rdy_s, logic [3:0] resp_s,
                                logic clr, logic e_rdy, logic e_resp, logic [31:0] e_data,
                                logic [15:0] e_cnt, logic [31:0] e_eaddr);
        vec_t v;
        v.rst = rst; v.trans = trans; v.sel = sel; v.herr = herr; v.addr = addr;
        v.rdy_s = rdy_s; v.resp_s = resp_s; v.clr = clr;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_data = e_data;
        v.e_cnt = e_cnt; v.e_eaddr = e_eaddr;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [1:0] trans, logic [3:0] sel, logic herr,
                         logic [31:0] addr, logic [3:0] rdy_s, logic [3:0] resp_s, logic clr);
        HRESET = rst; HTRANS = trans; HSELx = sel; HERROR = herr; HADDR = addr;
        HREADYOUT_S = rdy_s; HRESP_S = resp_s; ERR_CLR = clr;
    endtask

    initial begin
        HRDATA_S = {32'h4444_0003, 32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
        drive(1'b1, IDL, 4'b0000, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);

        //            rst trans sel     herr addr          rdy   resp  clr  rdy  rsp  data           cnt       eaddr
        // Reset state, then IDLE with no select
        vecs[0]  = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd0, 32'h0);
        // Mapped read to slave 2
        vecs[1]  = mk(0, NSQ, 4'b0100, 0, 32'h2000,     4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd0, 32'h0);
        vecs[2]  = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 0, 32'hDEADBEEF,  16'd0, 32'h0);
        // Slave 1 with three wait states; HSELx wiggles during the stall
        vecs[3]  = mk(0, NSQ, 4'b0010, 0, 32'h1000,     4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd0, 32'h0);
        vecs[4]  = mk(0, NSQ, 4'b1000, 0, 32'h3000,     4'hD, 4'h0, 0,   0, 0, 32'h22220001,  16'd0, 32'h0);
        vecs[5]  = mk(0, NSQ, 4'b0001, 0, 32'h3004,     4'hD, 4'h0, 0,   0, 0, 32'h22220001,  16'd0, 32'h0);
        vecs[6]  = mk(0, NSQ, 4'b0100, 0, 32'h3008,     4'hD, 4'h0, 0,   0, 0, 32'h22220001,  16'd0, 32'h0);
        vecs[7]  = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 0, 32'h22220001,  16'd0, 32'h0);
        // Unmapped via HERROR
        vecs[8]  = mk(0, NSQ, 4'b0000, 1, 32'hF0000010, 4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd0, 32'h0);
        vecs[9]  = mk(0, NSQ, 4'b0001, 0, 32'h5555,     4'hF, 4'h0, 0,   0, 1, 32'h0,         16'd1, 32'hF0000010);
        vecs[10] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 1, 32'h0,         16'd1, 32'hF0000010);
        vecs[11] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd1, 32'hF0000010);
        // Back-to-back: HSELx=0, then non-one-hot in ERR2, then slave 0 in ERR2
        vecs[12] = mk(0, NSQ, 4'b0000, 0, 32'h0A00,     4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd1, 32'hF0000010);
        vecs[13] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   0, 1, 32'h0,         16'd2, 32'h0A00);
        vecs[14] = mk(0, NSQ, 4'b0011, 0, 32'h0B00,     4'hF, 4'h0, 0,   1, 1, 32'h0,         16'd2, 32'h0A00);
        vecs[15] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   0, 1, 32'h0,         16'd3, 32'h0B00);
        vecs[16] = mk(0, NSQ, 4'b0001, 0, 32'h0,        4'hF, 4'h0, 0,   1, 1, 32'h0,         16'd3, 32'h0B00);
        vecs[17] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 0, 32'h11110000,  16'd3, 32'h0B00);
        // Slave-generated ERROR passes through
        vecs[18] = mk(0, SEQ, 4'b1000, 0, 32'h40,       4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd3, 32'h0B00);
        vecs[19] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h8, 0,   1, 1, 32'h44440003,  16'd3, 32'h0B00);
        // Clear coincident with an error entry
        vecs[20] = mk(0, NSQ, 4'b0100, 1, 32'h00C0,     4'hF, 4'h0, 1,   1, 0, 32'h0,         16'd3, 32'h0B00);
        vecs[21] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   0, 1, 32'h0,         16'd0, 32'h0);
        vecs[22] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 1, 32'h0,         16'd0, 32'h0);
        // BUSY to an unmapped address is not an error
        vecs[23] = mk(0, BSY, 4'b0000, 1, 32'h00C4,     4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd0, 32'h0);
        vecs[24] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd0, 32'h0);
        // Reset asserted during ERR1
        vecs[25] = mk(0, NSQ, 4'b0000, 1, 32'h00D0,     4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd0, 32'h0);
        vecs[26] = mk(1, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   0, 1, 32'h0,         16'd1, 32'h00D0);
        vecs[27] = mk(0, IDL, 4'b0000, 0, 32'h0,        4'hF, 4'h0, 0,   1, 0, 32'h0,         16'd0, 32'h0);

        repeat (2) @(posedge HCLK);
        for (int i = 0; i < NV; i++) begin
            #1;
            drive(vecs[i].rst, vecs[i].trans, vecs[i].sel, vecs[i].herr, vecs[i].addr,
                  vecs[i].rdy_s, vecs[i].resp_s, vecs[i].clr);
            #2;
            chk($sformatf("v%0d HREADY", i), {31'd0, HREADY}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d HRESP", i), {31'd0, HRESP}, {31'd0, vecs[i].e_resp});
            chk($sformatf("v%0d HRDATA", i), HRDATA, vecs[i].e_data);
            chk($sformatf("v%0d ERR_CNT", i), {16'd0, ERR_CNT}, {16'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d ERR_ADDR", i), ERR_ADDR, vecs[i].e_eaddr);
            @(posedge HCLK);
        end

        // Saturation: preload the counter near the top instead of replaying 65534 errors
        #1;
        drive(1'b0, IDL, 4'b0000, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        #1;
        drive(1'b0, NSQ, 4'b0000, 1'b1, 32'h00E0, 4'hF, 4'h0, 1'b0);
        @(posedge HCLK);
        #1;
        drive(1'b0, IDL, 4'b0000, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        #2;
        chk("sat inc to max", {16'd0, ERR_CNT}, 32'h0000_FFFF);
        chk("sat err1 ready", {31'd0, HREADY}, 32'd0);
        @(posedge HCLK);
        #1;
        drive(1'b0, NSQ, 4'b0000, 1'b1, 32'h00E4, 4'hF, 4'h0, 1'b0);
        #2;
        chk("sat err2 resp", {31'd0, HRESP}, 32'd1);
        @(posedge HCLK);
        #1;
        drive(1'b0, IDL, 4'b0000, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        #2;
        chk("sat hold", {16'd0, ERR_CNT}, 32'h0000_FFFF);
        chk("sat addr", ERR_ADDR, 32'h0000_00E4);
        repeat (2) @(posedge HCLK);
        #1;
        chk("sat idle ready", {31'd0, HREADY}, 32'd1);
        chk("sat idle resp", {31'd0, HRESP}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
